// File: rtl/mem_sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// mem_sram_controller_pkg
// Shared definitions for the memory-stage SRAM controller:
//   - state_t       : controller FSM states (IDLE -> LOW -> HIGH -> DONE)
//   - BASE_ADDR_DEFAULT : ARM byte address that maps to SRAM word 0
//   - HALF_LO/HALF_HI   : half-word select bit appended to the SRAM address
// -----------------------------------------------------------------------------
package mem_sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

    // Bits 15:0 of an ARM word live at the even SRAM address, 31:16 at the odd one.
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_sram_controller_if.sv
// -----------------------------------------------------------------------------
// mem_sram_controller_if
// Pipeline-side data-memory bus between the EXE/MEM register (master) and the
// memory-stage SRAM controller (slave).
//   wr_en, rd_en  : store / load request
//   address       : ARM byte address (ALU result)
//   write_data    : store data (Rm value)
//   read_data     : load result, registered in the controller
//   ready         : high = pipeline may advance
// -----------------------------------------------------------------------------
interface mem_sram_controller_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en,
        output rd_en,
        output address,
        output write_data,
        input  read_data,
        input  ready
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  address,
        input  write_data,
        output read_data,
        output ready
    );

endinterface

// File: rtl/mem_sram_controller.sv
// -----------------------------------------------------------------------------
// mem_sram_controller
// Memory-stage responder: turns one 32-bit ARM data access into two half-word
// accesses on an external 16-bit asynchronous SRAM (low half first) and holds
// ready low until the access completes.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   bus (slave)   : request/response bus from the EXE/MEM pipeline register
//   sram_addr     : SRAM half-word address
//   sram_dq_out   : write data to the pads;  sram_dq_in : read data from pads
//   sram_dq_oe    : pad output enable;       sram_we_n  : write strobe (low)
//   sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n : permanently enabled (0)
// -----------------------------------------------------------------------------
module mem_sram_controller
    import mem_sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_sram_controller_if.slave bus,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [15:0]          sram_dq_out,
    input  logic [15:0]          sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_ub_n,
    output logic                 sram_lb_n
);

    // Counter value on the final cycle of a LOW or HIGH phase.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t              state_r;
    state_t              next_state_s;
    logic [3:0]          wait_cnt_r;
    logic [SRAM_AW-2:0]  word_r;
    logic [31:0]         wdata_r;
    logic                is_write_r;
    logic [31:0]         read_data_r;
    logic                req_s;
    logic                capture_s;
    logic                last_wait_s;
    logic [31:0]         offset_s;
    logic                unused_offset_s;

    assign req_s       = bus.rd_en | bus.wr_en;
    assign capture_s   = (state_r == IDLE) && req_s;
    assign last_wait_s = (wait_cnt_r == WAIT_LAST);

    // Byte offset from the SRAM window base; wraps modulo 2^32 for addresses below it.
    assign offset_s = bus.address - BASE_ADDR;

    // Byte-lane bits and word bits beyond the SRAM depth are deliberately dropped.
    assign unused_offset_s = ^{offset_s[31:SRAM_AW+1], offset_s[1:0]};

    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    assign bus.read_data = read_data_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic: each half-word phase lasts WAIT_CYCLES cycles.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) next_state_s = LOW;
                else       next_state_s = IDLE;
            end
            LOW: begin
                if (last_wait_s) next_state_s = HIGH;
                else             next_state_s = LOW;
            end
            HIGH: begin
                if (last_wait_s) next_state_s = DONE;
                else             next_state_s = HIGH;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs: SRAM pins come only from latched request state, never live inputs.
    always_comb begin
        sram_addr   = {SRAM_AW{1'b0}};
        sram_dq_out = 16'h0000;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        bus.ready   = 1'b0;
        case (state_r)
            IDLE: bus.ready = !req_s;
            LOW, HIGH: begin
                sram_addr = {word_r, (state_r == HIGH) ? HALF_HI : HALF_LO};
                if (is_write_r) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = (state_r == HIGH) ? wdata_r[31:16] : wdata_r[15:0];
                end else begin
                    sram_we_n   = 1'b1;
                    sram_dq_oe  = 1'b0;
                end
            end
            DONE:    bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
    end

    // Phase counter: restarts at zero on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= 4'd0;
        end else if (next_state_s != state_r) begin
            wait_cnt_r <= 4'd0;
        end else if ((state_r == LOW) || (state_r == HIGH)) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Request latch; write wins when both enables are high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_r     <= {(SRAM_AW-1){1'b0}};
            wdata_r    <= 32'h0000_0000;
            is_write_r <= 1'b0;
        end else if (capture_s) begin
            word_r     <= offset_s[SRAM_AW:2];
            wdata_r    <= bus.write_data;
            is_write_r <= bus.wr_en;
        end else begin
            word_r     <= word_r;
            wdata_r    <= wdata_r;
            is_write_r <= is_write_r;
        end
    end

    // Load result: each half is sampled at the edge closing its phase; writes never touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data_r <= 32'h0000_0000;
        end else if (!is_write_r && last_wait_s && (state_r == LOW)) begin
            read_data_r[15:0] <= sram_dq_in;
        end else if (!is_write_r && last_wait_s && (state_r == HIGH)) begin
            read_data_r[31:16] <= sram_dq_in;
        end else begin
            read_data_r <= read_data_r;
        end
    end

endmodule

// File: doc/mem_sram_controller.md
Name: mem_sram_controller

Overview:
- Memory-stage responder for the data-memory requests the execute stage issues: address = ALU result, store data = Rm value, plus read/write enables.
- Maps each 32-bit ARM word access onto an external 16-bit asynchronous SRAM as two half-word accesses (low half first).
- Holds ready low to freeze the pipeline until the access completes.
- Sits between the EXE/MEM pipeline register and the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: ARM byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles each half-word access is held on the SRAM pins; legal range 1..15.
- SRAM_AW, 18: SRAM address width (half-word granularity).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- wr_en  in  1  store request from EXE/MEM.
- rd_en  in  1  load request from EXE/MEM.
- address  in  32  ARM byte address (ALU result).
- write_data  in  32  store data (Rm value).
- read_data  out  32  load result, registered.
- ready  out  1  high = pipeline may advance.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  write data to the SRAM pads.
- sram_dq_in  in  16  read data from the SRAM pads.
- sram_dq_oe  out  1  pad output enable.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  tied 0.

Behaviour:
- Request capture:
  - In IDLE, if rd_en|wr_en is sampled at a clock edge, latch address, write_data and op.
  - If both enables are high, write wins and read_data is left unchanged.
- Address mapping: word = (address − BASE_ADDR) >> 2, modulo 2^32; address[1:0] ignored. sram_addr = {word[SRAM_AW−2:0], half}, with half 0 = bits 15:0 and half 1 = bits 31:16.
- States: IDLE → LOW → HIGH → DONE → IDLE.
  - LOW and HIGH each last exactly WAIT_CYCLES cycles, counted by a wait counter cleared on every state entry.
  - DONE lasts one cycle.
- ready is combinational:
  - 1 when state = IDLE and !(rd_en|wr_en), or when state = DONE.
  - 0 otherwise, including the IDLE cycle in which a request first appears.
- Latency: with the request appearing in cycle 0, LOW covers cycles 1..W, HIGH covers W+1..2W, DONE is cycle 2W+1. Stall is 2W+1 cycles; W=2 gives ready high at cycle 5.
- SRAM pins in LOW/HIGH, driven from latched registers only (never from live inputs):
  - sram_addr = mapped half-word address.
  - Write: sram_we_n = 0, sram_dq_oe = 1, sram_dq_out = the selected half of the latched data.
  - Read: sram_we_n = 1, sram_dq_oe = 0.
- Read capture:
  - Low half of read_data takes sram_dq_in at the edge ending the last LOW cycle.
  - High half takes sram_dq_in at the edge ending the last HIGH cycle.
  - read_data is stable from DONE until the next read completes; writes never change it.
- Pins in IDLE/DONE: sram_addr = 0, sram_we_n = 1, sram_dq_oe = 0, sram_dq_out = 0.
- Back-to-back requests: a request present in the IDLE cycle after DONE is a new transaction, since the pipeline advanced at the DONE edge. It starts immediately.
- Enable changes: rd_en/wr_en changes after capture are ignored until DONE.
- Reset values: state IDLE, wait counter 0, read_data 0, all latches 0, sram_we_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_out 0.
- Reset mid-operation: rst low forces the reset values immediately, without waiting for a clock edge. A write interrupted in HIGH has its low half already written; this partial write is accepted.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, LOW, HIGH, DONE};
  - the BASE_ADDR default;
  - the SRAM half-select constants.
- No RTL sub-module; the FSM, counter and datapath stay in one block.
- The bench provides a behavioural SRAM model, sram_model, with zero-delay read and write on sram_we_n low.

Test Plan:
- Reset: rst=0 mid-simulation with no request → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0 before the next clk edge.
- Write, W=2: wr_en=1, address=1032, write_data=0xDEADBEEF in cycle 0 →
  - cycles 1-2: sram_addr=4, sram_dq_out=0xBEEF, sram_we_n=0;
  - cycles 3-4: sram_addr=5, sram_dq_out=0xDEAD;
  - cycle 5: ready=1 for exactly one cycle.
- Read back: rd_en=1, address=1032 → read_data=0xDEADBEEF in cycle 5, sram_dq_oe=0 throughout, ready low in cycles 0-4.
- Back-to-back: rd_en held high across DONE → ready=1 in cycle 5, 0 again in cycle 6, second DONE in cycle 11.
- Conflict: rd_en=wr_en=1 at address 1024 with data 0x12345678 → model words 0/1 = 0x5678/0x1234; read_data unchanged.
- Reset in HIGH of a write → IDLE at once, sram_we_n=1; only the low half is present in the model; the next request completes normally in 2W+2 cycles.
